// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_pkg
// Purpose  : Shared configuration for the reorder buffer, the decoder and the
//            register file: buffer sizing and the instruction type codes
//            carried in each entry.
// Revision : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

  // log2 of the number of entries
  localparam int ROB_SIZE_BIT = 3;
  // width of the instruction type code
  localparam int ROB_TYPE_BIT = 2;

  // Instruction type codes
  localparam logic [ROB_TYPE_BIT-1:0] ROB_REG    = 2'b00;
  localparam logic [ROB_TYPE_BIT-1:0] ROB_STORE  = 2'b01;
  localparam logic [ROB_TYPE_BIT-1:0] ROB_BRANCH = 2'b10;
  localparam logic [ROB_TYPE_BIT-1:0] ROB_HALT   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : Circular in-order retirement buffer for the out-of-order core.
//            Allocates one entry per issued instruction, captures results
//            from the common data bus, answers two operand queries
//            combinationally and retires completed entries in program order
//            to the register file / load-store buffer. A mispredicted branch
//            raises a one-cycle flush on retire.
// Ports    : clk_in, rst_in (async, active-high), rdy_in (global stall)
//            issue_*   : instruction allocation, issue_id = next id, full
//            qry1/2_*  : operand dependency lookups (combinational)
//            cdb_*     : result broadcast
//            commit_*  : register write / retire info, store_commit pulse
//            halt      : sticky stop, clear/clear_pc : pipeline flush
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int ROB_SIZE_BIT = reorder_buffer_pkg::ROB_SIZE_BIT,
  parameter int ROB_TYPE_BIT = reorder_buffer_pkg::ROB_TYPE_BIT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  // issue
  input  logic                    issue_valid,
  input  logic [ROB_TYPE_BIT-1:0] issue_type,
  input  logic [4:0]              issue_reg_id,
  input  logic [31:0]             issue_value,
  input  logic [31:0]             issue_addr,
  input  logic                    issue_fi,
  output logic [ROB_SIZE_BIT-1:0] issue_id,
  output logic                    full,
  // operand queries
  input  logic [ROB_SIZE_BIT-1:0] qry1_id,
  input  logic [ROB_SIZE_BIT-1:0] qry2_id,
  output logic                    qry1_fi,
  output logic                    qry2_fi,
  output logic [31:0]             qry1_value,
  output logic [31:0]             qry2_value,
  // common data bus
  input  logic                    cdb_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb_id,
  input  logic [31:0]             cdb_value,
  input  logic                    cdb_redirect,
  input  logic [31:0]             cdb_target,
  // retire
  output logic                    commit_valid,
  output logic [ROB_SIZE_BIT-1:0] commit_rob_id,
  output logic [4:0]              commit_reg_id,
  output logic [31:0]             commit_value,
  output logic                    store_commit,
  output logic                    halt,
  output logic                    clear,
  output logic [31:0]             clear_pc
);

  import reorder_buffer_pkg::*;

  localparam int                  C_DEPTH        = 1 << ROB_SIZE_BIT;
  localparam logic [ROB_SIZE_BIT:0] C_COUNT_FULL = (ROB_SIZE_BIT+1)'(C_DEPTH);
  localparam logic [ROB_SIZE_BIT:0] C_COUNT_RSV  = (ROB_SIZE_BIT+1)'(C_DEPTH - 1);

  // Entry storage
  logic                    r_busy     [C_DEPTH];
  logic                    r_fi       [C_DEPTH];
  logic [ROB_TYPE_BIT-1:0] r_type     [C_DEPTH];
  logic [4:0]              r_reg_id   [C_DEPTH];
  logic [31:0]             r_value    [C_DEPTH];
  logic [31:0]             r_addr     [C_DEPTH];
  logic                    r_redirect [C_DEPTH];
  logic [31:0]             r_target   [C_DEPTH];

  logic [ROB_SIZE_BIT-1:0] r_head;
  logic [ROB_SIZE_BIT-1:0] r_tail;
  logic [ROB_SIZE_BIT:0]   r_count;

  logic        w_issue;
  logic        w_retire;
  logic        w_cdb_wr;
  logic        w_head_reg_nz;
  logic        w_qry1_hit;
  logic        w_qry2_hit;
  // PC of the oldest entry: carried for debug visibility only
  logic [31:0] w_unused_head_addr;

  assign issue_id = r_tail;
  // One slot stays in reserve because the issue stage has a request in flight
  assign full     = (r_count >= C_COUNT_RSV);

  // The clear cycle blocks issue and retire; the flush wipes the buffer next edge.
  // An issue at count == DEPTH is a protocol violation and is dropped.
  assign w_issue  = rdy_in && !clear && issue_valid && (r_count != C_COUNT_FULL);
  // Retire only on the stored finish bit, never on a same-cycle CDB hit
  assign w_retire = rdy_in && !clear && (r_count != '0) && r_fi[r_head];
  assign w_cdb_wr = rdy_in && !clear && cdb_valid && r_busy[cdb_id];

  assign w_head_reg_nz      = (r_reg_id[r_head] != 5'd0);
  assign w_unused_head_addr = r_addr[r_head];

  // Operand queries with same-cycle CDB forwarding
  assign w_qry1_hit = cdb_valid && (cdb_id == qry1_id);
  assign w_qry2_hit = cdb_valid && (cdb_id == qry2_id);
  assign qry1_fi    = r_busy[qry1_id] && (r_fi[qry1_id] || w_qry1_hit);
  assign qry2_fi    = r_busy[qry2_id] && (r_fi[qry2_id] || w_qry2_hit);
  assign qry1_value = !r_busy[qry1_id] ? 32'd0 : (w_qry1_hit ? cdb_value : r_value[qry1_id]);
  assign qry2_value = !r_busy[qry2_id] ? 32'd0 : (w_qry2_hit ? cdb_value : r_value[qry2_id]);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < C_DEPTH; i++) begin
        r_busy[i]     <= 1'b0;
        r_fi[i]       <= 1'b0;
        r_type[i]     <= '0;
        r_reg_id[i]   <= '0;
        r_value[i]    <= '0;
        r_addr[i]     <= '0;
        r_redirect[i] <= 1'b0;
        r_target[i]   <= '0;
      end
      commit_valid  <= 1'b0;
      commit_rob_id <= '0;
      commit_reg_id <= '0;
      commit_value  <= '0;
      store_commit  <= 1'b0;
      halt          <= 1'b0;
      clear         <= 1'b0;
      clear_pc      <= '0;
    end else if (clear) begin
      // Flush completes even if rdy_in dropped, so the clear pulse is never lost
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < C_DEPTH; i++) begin
        r_busy[i] <= 1'b0;
      end
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      clear        <= 1'b0;
    end else begin
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      clear        <= 1'b0;

      if (w_issue) begin
        r_busy[r_tail]     <= 1'b1;
        r_fi[r_tail]       <= issue_fi;
        r_type[r_tail]     <= issue_type;
        r_reg_id[r_tail]   <= issue_reg_id;
        r_value[r_tail]    <= issue_value;
        r_addr[r_tail]     <= issue_addr;
        r_redirect[r_tail] <= 1'b0;
        r_target[r_tail]   <= '0;
        r_tail             <= r_tail + ROB_SIZE_BIT'(1);
      end

      if (w_cdb_wr) begin
        r_value[cdb_id]    <= cdb_value;
        r_fi[cdb_id]       <= 1'b1;
        r_redirect[cdb_id] <= cdb_redirect;
        r_target[cdb_id]   <= cdb_target;
      end

      if (w_retire) begin
        r_busy[r_head] <= 1'b0;
        r_head         <= r_head + ROB_SIZE_BIT'(1);
        commit_rob_id  <= r_head;
        commit_reg_id  <= r_reg_id[r_head];
        commit_value   <= r_value[r_head];
        case (r_type[r_head])
          ROB_REG:    commit_valid <= w_head_reg_nz;
          ROB_STORE:  store_commit <= 1'b1;
          ROB_BRANCH: begin
            commit_valid <= w_head_reg_nz;
            if (r_redirect[r_head]) begin
              clear    <= 1'b1;
              clear_pc <= r_target[r_head];
            end
          end
          default:    halt <= 1'b1;
        endcase
      end

      r_count <= r_count + (ROB_SIZE_BIT+1)'(w_issue) - (ROB_SIZE_BIT+1)'(w_retire);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Purpose  : Self-checking bench for reorder_buffer. A table of per-cycle
//            vectors covers basic issue/commit/forwarding; hand sequences
//            cover fill and wrap, out-of-order completion, branch flush,
//            stall on rdy_in, halt and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

  import reorder_buffer_pkg::*;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        issue_valid;
  logic [1:0]  issue_type;
  logic [4:0]  issue_reg_id;
  logic [31:0] issue_value;
  logic [31:0] issue_addr;
  logic        issue_fi;
  logic [2:0]  issue_id;
  logic        full;
  logic [2:0]  qry1_id;
  logic [2:0]  qry2_id;
  logic        qry1_fi;
  logic        qry2_fi;
  logic [31:0] qry1_value;
  logic [31:0] qry2_value;
  logic        cdb_valid;
  logic [2:0]  cdb_id;
  logic [31:0] cdb_value;
  logic        cdb_redirect;
  logic [31:0] cdb_target;
  logic        commit_valid;
  logic [2:0]  commit_rob_id;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_value;
  logic        store_commit;
  logic        halt;
  logic        clear;
  logic [31:0] clear_pc;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .issue_valid   (issue_valid),
    .issue_type    (issue_type),
    .issue_reg_id  (issue_reg_id),
    .issue_value   (issue_value),
    .issue_addr    (issue_addr),
    .issue_fi      (issue_fi),
    .issue_id      (issue_id),
    .full          (full),
    .qry1_id       (qry1_id),
    .qry2_id       (qry2_id),
    .qry1_fi       (qry1_fi),
    .qry2_fi       (qry2_fi),
    .qry1_value    (qry1_value),
    .qry2_value    (qry2_value),
    .cdb_valid     (cdb_valid),
    .cdb_id        (cdb_id),
    .cdb_value     (cdb_value),
    .cdb_redirect  (cdb_redirect),
    .cdb_target    (cdb_target),
    .commit_valid  (commit_valid),
    .commit_rob_id (commit_rob_id),
    .commit_reg_id (commit_reg_id),
    .commit_value  (commit_value),
    .store_commit  (store_commit),
    .halt          (halt),
    .clear         (clear),
    .clear_pc      (clear_pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // One vector = inputs held for one cycle plus outputs expected 1 time unit
  // after they are applied (registered outputs reflect the previous edge).
  typedef struct {
    logic        rdy;
    logic        iv;
    logic [1:0]  it;
    logic [4:0]  ir;
    logic [31:0] ival;
    logic        ifi;
    logic        cv;
    logic [2:0]  cid;
    logic [31:0] cval;
    logic [2:0]  q1;
    logic [2:0]  e_id;
    logic        e_full;
    logic        e_q1fi;
    logic [31:0] e_q1val;
    logic        e_cv;
    logic [4:0]  e_creg;
    logic [31:0] e_cval;
    logic [2:0]  e_crob;
    logic        e_sc;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    issue_type   = ROB_REG;
    issue_reg_id = 5'd0;
    issue_value  = 32'd0;
    issue_addr   = 32'd0;
    issue_fi     = 1'b0;
    cdb_valid    = 1'b0;
    cdb_id       = 3'd0;
    cdb_value    = 32'd0;
    cdb_redirect = 1'b0;
    cdb_target   = 32'd0;
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] r, input logic [31:0] v,
                          input logic f);
    issue_valid  = 1'b1;
    issue_type   = t;
    issue_reg_id = r;
    issue_value  = v;
    issue_addr   = 32'h1000 + 32'(r);
    issue_fi     = f;
  endtask

  task automatic do_cdb(input logic [2:0] id, input logic [31:0] v, input logic rd,
                        input logic [31:0] tg);
    cdb_valid    = 1'b1;
    cdb_id       = id;
    cdb_value    = v;
    cdb_redirect = rd;
    cdb_target   = tg;
  endtask

  // Advance to the next negedge and reset the strobes
  task automatic cyc();
    @(negedge clk_in);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {rdy,iv,type,reg,ival,ifi, cv,cid,cval, q1, e_id,e_full,e_q1fi,e_q1val, e_cv,e_creg,e_cval,e_crob,e_sc}
    vecs[0]  = '{1'b1, 1'b0, ROB_REG, 5'd0, 32'h0,        1'b0, 1'b0, 3'd0, 32'h0,  3'd0,
                 3'd0, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, ROB_REG, 5'd5, 32'h12345000, 1'b1, 1'b0, 3'd0, 32'h0,  3'd0,
                 3'd0, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, ROB_REG, 5'd0, 32'h0,        1'b0, 1'b0, 3'd0, 32'h0,  3'd0,
                 3'd1, 1'b0, 1'b1, 32'h12345000, 1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, ROB_REG, 5'd0, 32'h0,        1'b0, 1'b0, 3'd0, 32'h0,  3'd0,
                 3'd1, 1'b0, 1'b0, 32'h0,        1'b1, 5'd5, 32'h12345000, 3'd0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, ROB_REG, 5'd3, 32'h0,        1'b0, 1'b0, 3'd0, 32'h0,  3'd1,
                 3'd1, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, ROB_REG, 5'd0, 32'h0,        1'b0, 1'b1, 3'd1, 32'h7,  3'd1,
                 3'd2, 1'b0, 1'b1, 32'h7,        1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, ROB_REG, 5'd0, 32'h0,        1'b0, 1'b0, 3'd0, 32'h0,  3'd1,
                 3'd2, 1'b0, 1'b1, 32'h7,        1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, ROB_REG, 5'd0, 32'h0,        1'b0, 1'b0, 3'd0, 32'h0,  3'd1,
                 3'd2, 1'b0, 1'b0, 32'h0,        1'b1, 5'd3, 32'h7,        3'd1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, ROB_REG, 5'd0, 32'h0,        1'b0, 1'b1, 3'd5, 32'h99, 3'd5,
                 3'd2, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, ROB_REG, 5'd0, 32'hAA,       1'b1, 1'b0, 3'd0, 32'h0,  3'd2,
                 3'd2, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, ROB_REG, 5'd0, 32'h0,        1'b0, 1'b0, 3'd0, 32'h0,  3'd2,
                 3'd3, 1'b0, 1'b1, 32'hAA,       1'b0, 5'd0, 32'h0,        3'd0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, ROB_REG, 5'd0, 32'h0,        1'b0, 1'b0, 3'd0, 32'h0,  3'd2,
                 3'd3, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0,        3'd0, 1'b0};

    // ---------------- reset ----------------
    rst_in  = 1'b1;
    rdy_in  = 1'b1;
    qry1_id = 3'd0;
    qry2_id = 3'd0;
    idle();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst issue_id",     32'(issue_id),     32'd0);
    chk("rst full",         32'(full),         32'd0);
    chk("rst commit_valid", 32'(commit_valid), 32'd0);
    chk("rst store_commit", 32'(store_commit), 32'd0);
    chk("rst halt",         32'(halt),         32'd0);
    chk("rst clear",        32'(clear),        32'd0);
    chk("rst clear_pc",     clear_pc,          32'd0);
    chk("rst commit_value", commit_value,      32'd0);
    rst_in = 1'b0;

    // ---------------- table vectors ----------------
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk_in);
      rdy_in       = vecs[i].rdy;
      issue_valid  = vecs[i].iv;
      issue_type   = vecs[i].it;
      issue_reg_id = vecs[i].ir;
      issue_value  = vecs[i].ival;
      issue_addr   = 32'h2000 + 32'(i);
      issue_fi     = vecs[i].ifi;
      cdb_valid    = vecs[i].cv;
      cdb_id       = vecs[i].cid;
      cdb_value    = vecs[i].cval;
      cdb_redirect = 1'b0;
      cdb_target   = 32'd0;
      qry1_id      = vecs[i].q1;
      qry2_id      = vecs[i].q1;
      #1;
      chk($sformatf("v%0d issue_id", i),     32'(issue_id),     32'(vecs[i].e_id));
      chk($sformatf("v%0d full", i),         32'(full),         32'(vecs[i].e_full));
      chk($sformatf("v%0d qry1_fi", i),      32'(qry1_fi),      32'(vecs[i].e_q1fi));
      chk($sformatf("v%0d qry1_value", i),   qry1_value,        vecs[i].e_q1val);
      chk($sformatf("v%0d qry2_fi", i),      32'(qry2_fi),      32'(vecs[i].e_q1fi));
      chk($sformatf("v%0d commit_valid", i), 32'(commit_valid), 32'(vecs[i].e_cv));
      chk($sformatf("v%0d store_commit", i), 32'(store_commit), 32'(vecs[i].e_sc));
      if (vecs[i].e_cv) begin
        chk($sformatf("v%0d commit_reg_id", i), 32'(commit_reg_id), 32'(vecs[i].e_creg));
        chk($sformatf("v%0d commit_value", i),  commit_value,       vecs[i].e_cval);
        chk($sformatf("v%0d commit_rob_id", i), 32'(commit_rob_id), 32'(vecs[i].e_crob));
      end
    end

    // ---------------- fill, wrap, overfill, out-of-order completion ----------------
    // head = tail = 3 here; eight issues occupy ids 3..7,0,1,2 with regs 1..8
    for (int i = 0; i < 8; i++) begin
      cyc();
      #1;
      chk($sformatf("fill%0d issue_id", i), 32'(issue_id), 32'((3 + i) % 8));
      chk($sformatf("fill%0d full", i),     32'(full),     32'(i >= 7));
      do_issue(ROB_REG, 5'(i + 1), 32'd0, 1'b0);
    end
    cyc();
    qry1_id = 3'd3;
    #1;
    chk("fill8 issue_id", 32'(issue_id), 32'd3);
    chk("fill8 full",     32'(full),     32'd1);
    do_issue(ROB_REG, 5'd9, 32'hDEAD, 1'b1);   // count == DEPTH: must be ignored
    cyc();
    #1;
    chk("overfill issue_id", 32'(issue_id), 32'd3);
    chk("overfill qry1_fi",  32'(qry1_fi),  32'd0);
    do_cdb(3'd4, 32'h44, 1'b0, 32'd0);
    cyc();
    qry1_id = 3'd4;
    #1;
    chk("ooo qry1_fi",      32'(qry1_fi),      32'd1);
    chk("ooo qry1_value",   qry1_value,        32'h44);
    chk("ooo commit_valid", 32'(commit_valid), 32'd0);
    cyc();
    #1;
    chk("ooo wait commit_valid", 32'(commit_valid), 32'd0);
    do_cdb(3'd3, 32'h33, 1'b0, 32'd0);
    cyc();
    #1;
    chk("ooo latency commit_valid", 32'(commit_valid), 32'd0);
    cyc();
    #1;
    chk("ooo c3 commit_valid",  32'(commit_valid),  32'd1);
    chk("ooo c3 commit_rob_id", 32'(commit_rob_id), 32'd3);
    chk("ooo c3 commit_reg_id", 32'(commit_reg_id), 32'd1);
    chk("ooo c3 commit_value",  commit_value,       32'h33);
    chk("ooo c3 full",          32'(full),          32'd1);
    cyc();
    #1;
    chk("ooo c4 commit_valid",  32'(commit_valid),  32'd1);
    chk("ooo c4 commit_rob_id", 32'(commit_rob_id), 32'd4);
    chk("ooo c4 commit_reg_id", 32'(commit_reg_id), 32'd2);
    chk("ooo c4 commit_value",  commit_value,       32'h44);
    chk("ooo c4 full",          32'(full),          32'd0);
    cyc();
    #1;
    chk("ooo idle commit_valid", 32'(commit_valid), 32'd0);

    // ---------------- asynchronous reset mid-operation ----------------
    rst_in = 1'b1;
    #1;
    chk("midrst issue_id", 32'(issue_id), 32'd0);
    chk("midrst full",     32'(full),     32'd0);
    cyc();
    rst_in = 1'b0;

    // ---------------- branch mispredict flush ----------------
    do_issue(ROB_REG, 5'd1, 32'd0, 1'b0);                 // id 0
    cyc(); do_issue(ROB_REG, 5'd2, 32'd0, 1'b0);          // id 1
    cyc(); do_issue(ROB_BRANCH, 5'd4, 32'd0, 1'b0);       // id 2
    cyc(); do_issue(ROB_REG, 5'd5, 32'd0, 1'b0);          // id 3
    cyc(); do_issue(ROB_REG, 5'd6, 32'd0, 1'b0);          // id 4
    do_cdb(3'd0, 32'd1, 1'b0, 32'd0);
    cyc(); do_cdb(3'd1, 32'd2, 1'b0, 32'd0);
    cyc();
    #1;
    chk("br c0 commit_valid",  32'(commit_valid),  32'd1);
    chk("br c0 commit_rob_id", 32'(commit_rob_id), 32'd0);
    chk("br c0 commit_value",  commit_value,       32'd1);
    do_cdb(3'd2, 32'h88, 1'b1, 32'h100);
    cyc();
    #1;
    chk("br c1 commit_rob_id", 32'(commit_rob_id), 32'd1);
    chk("br c1 clear",         32'(clear),         32'd0);
    cyc();
    #1;
    chk("br c2 commit_valid",  32'(commit_valid),  32'd1);
    chk("br c2 commit_rob_id", 32'(commit_rob_id), 32'd2);
    chk("br c2 commit_reg_id", 32'(commit_reg_id), 32'd4);
    chk("br c2 commit_value",  commit_value,       32'h88);
    chk("br c2 clear",         32'(clear),         32'd1);
    chk("br c2 clear_pc",      clear_pc,           32'h100);
    do_issue(ROB_REG, 5'd7, 32'h77, 1'b1);                // dropped in clear cycle
    cyc();
    qry1_id = 3'd3;
    #1;
    chk("flush clear",        32'(clear),        32'd0);
    chk("flush issue_id",     32'(issue_id),     32'd0);
    chk("flush full",         32'(full),         32'd0);
    chk("flush commit_valid", 32'(commit_valid), 32'd0);
    chk("flush qry1_fi",      32'(qry1_fi),      32'd0);
    do_cdb(3'd3, 32'h5, 1'b0, 32'd0);                    // targets a flushed entry
    cyc();
    #1;
    chk("flush cdb qry1_fi",  32'(qry1_fi),      32'd0);
    chk("flush cdb issue_id", 32'(issue_id),     32'd0);
    chk("flush no commit",    32'(commit_valid), 32'd0);

    // ---------------- store held back by rdy_in ----------------
    do_issue(ROB_STORE, 5'd0, 32'd0, 1'b0);               // id 0
    cyc(); do_cdb(3'd0, 32'd0, 1'b0, 32'd0);
    cyc(); rdy_in = 1'b0;
    #1;
    chk("st stall0 store_commit", 32'(store_commit), 32'd0);
    cyc(); do_issue(ROB_REG, 5'd7, 32'd0, 1'b1);          // ignored while stalled
    #1;
    chk("st stall1 store_commit", 32'(store_commit), 32'd0);
    cyc();
    #1;
    chk("st stall2 store_commit", 32'(store_commit), 32'd0);
    chk("st stall issue_id",      32'(issue_id),     32'd1);
    cyc(); rdy_in = 1'b1;
    #1;
    chk("st resume store_commit", 32'(store_commit), 32'd0);
    cyc();
    #1;
    chk("st store_commit",  32'(store_commit),  32'd1);
    chk("st commit_rob_id", 32'(commit_rob_id), 32'd0);
    chk("st commit_valid",  32'(commit_valid),  32'd0);
    cyc();
    #1;
    chk("st pulse end", 32'(store_commit), 32'd0);

    // ---------------- halt ----------------
    chk("halt before", 32'(halt), 32'd0);
    do_issue(ROB_HALT, 5'd0, 32'd0, 1'b1);                // id 1
    cyc();
    #1;
    chk("halt pending", 32'(halt), 32'd0);
    cyc();
    #1;
    chk("halt set",          32'(halt),         32'd1);
    chk("halt commit_valid", 32'(commit_valid), 32'd0);
    cyc();
    #1;
    chk("halt sticky", 32'(halt), 32'd1);
    rst_in = 1'b1;
    #1;
    chk("halt reset", 32'(halt), 32'd0);
    cyc();
    rst_in = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
